// File: rtl/serial_sub_pkg.sv
// Shared state encoding for the bit-serial subtractor controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// Single-bit full subtractor; the one arithmetic cell reused every RUN cycle.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor {bout,diff} = a - b - bin, LSB first,
// driven by an IDLE/RUN/DONE FSM around a single full_sub_cell.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_brw;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d_bit;
  logic             w_bo_bit;
  logic             w_accept;
  logic             w_last;

  full_sub_cell u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_brw),
    .diff (w_d_bit),
    .bout (w_bo_bit)
  );

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_RUN) && (r_count == LAST_BIT);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_brw   <= 1'b0;
      r_count <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_brw   <= bin;
      r_count <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at diff[0].
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_diff  <= {w_d_bit, r_diff[WIDTH-1:1]};
      r_brw   <= w_bo_bit;
      r_count <= r_count + 1'b1;
      if (w_last) r_bout <= w_bo_bit;
    end
  end

  assign ready = (r_state == ST_IDLE);
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign diff  = r_diff;
  assign bout  = r_bout;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench: hand-computed vector table, multi-cycle corner sequences,
// and random operands against an arithmetic reference.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, wait for done (bounded), return result and edge count; leaves FSM in IDLE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        output logic [W-1:0] od, output logic ob, output int lat);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    od = diff;
    ob = bout;
    tick();
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
  endfunction

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    int           lat;
    int           n_done;
    logic [W:0]   exp;
    logic [W-1:0] ra, rbb;
    logic         rbin;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_diff",  32'(diff),  32'd0);
    check("reset_bout",  32'(bout),  32'd0);
    rst = 1'b0;
    tick();

    // Table vectors: result, latency and single-cycle done.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, rd, rb, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
      check($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].exp_diff));
      check($sformatf("vec%0d_bout", i), 32'(rb), 32'(vecs[i].exp_bout));
      check($sformatf("vec%0d_done_drop", i), 32'({ready, busy, done}), 32'b100);
    end

    // Result held through IDLE while operands wander, cleared on next accept.
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      tick();
      check("hold_diff", 32'(diff), 32'(vecs[7].exp_diff));
      check("hold_bout", 32'(bout), 32'(vecs[7].exp_bout));
    end
    run_op(8'h80, 8'h7F, 1'b1, rd, rb, lat);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_clears_diff", 32'(diff), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    check("after_hold_diff", 32'(diff), 32'h22);
    tick();

    // Start held high with changing operands through RUN and DONE.
    a = 8'hC3; b = 8'h45; bin = 1'b1; start = 1'b1;
    tick();
    n_done = 0;
    lat = 0;
    while (!done && lat < 40) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      check("hold_start_not_ready", 32'(ready), 32'd0);
      tick();
      lat++;
    end
    if (done) n_done++;
    check("hold_start_latency", 32'(lat), 32'(W));
    check("hold_start_diff", 32'(diff), 32'h7D);
    a = 8'h09; b = 8'h0A; bin = 1'b0;
    tick();
    check("hold_start_idle", 32'({ready, busy, done}), 32'b100);
    tick();
    if (done) n_done++;
    check("hold_start_single_done", 32'(n_done), 32'd1);
    check("hold_start_accept", 32'(busy), 32'd1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    check("second_op_diff", 32'(diff), 32'hFF);
    check("second_op_bout", 32'(bout), 32'd1);
    tick();

    // Reset asserted mid-RUN at count 4.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    check("midrst_state", 32'({ready, busy, done}), 32'b100);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run_op(8'h5A, 8'h3C, 1'b0, rd, rb, lat);
    check("postrst_diff", 32'(rd), 32'h1E);
    check("postrst_bout", 32'(rb), 32'd0);

    // Random back-to-back operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rbb = 8'($urandom); rbin = 1'($urandom);
      exp = model(ra, rbb, rbin);
      run_op(ra, rbb, rbin, rd, rb, lat);
      check($sformatf("rand%0d_result", i), 32'({rb, rd}), 32'(exp));
      if (lat != W) check($sformatf("rand%0d_latency", i), 32'(lat), 32'(W));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
